// File: rtl/pipelined_barrel_shifter.sv
// Pipelined LSL/LSR/ASR/ROR barrel shifter with one stage per shift-amount bit
// and a valid/ready handshake whose ready chain lets bubbles collapse.
module pipelined_barrel_shifter #(
    parameter int WIDTH = 8,
    localparam int SW = $clog2(WIDTH)
) (
    input  logic             CLK,
    input  logic             RESETN,
    input  logic [WIDTH-1:0] I,
    input  logic [SW-1:0]    S,
    input  logic [1:0]       OP,
    input  logic             I_VALID,
    output logic             I_READY,
    output logic [WIDTH-1:0] O,
    output logic             O_VALID,
    input  logic             O_READY
);

    // The last stage never needs the shift amount or mode, so only SW-1 stages carry them.
    localparam int NCTL = (SW > 1) ? SW - 1 : 1;

    logic [SW-1:0]    valid_q;
    logic [WIDTH-1:0] data_q [SW];
    logic [SW-1:0]    s_q    [NCTL];
    logic [1:0]       op_q   [NCTL];

    logic [SW:0]      ready;
    logic [SW-1:0]    in_valid;
    logic [WIDTH-1:0] in_data [SW];
    logic [SW-1:0]    in_s    [SW];
    logic [1:0]       in_op   [SW];
    logic [WIDTH-1:0] shifted [SW];

    function automatic logic [WIDTH-1:0] shift_pow2(input logic [WIDTH-1:0] d,
                                                    input logic [1:0] op,
                                                    input int k);
        int amt;
        amt = 1 << k;
        case (op)
            2'b00:   return d << amt;
            2'b01:   return d >> amt;
            2'b10:   return WIDTH'($signed(d) >>> amt);
            default: return (d >> amt) | (d << (WIDTH - amt));
        endcase
    endfunction

    always_comb begin
        in_valid[0] = I_VALID;
        in_data[0]  = I;
        in_s[0]     = S;
        in_op[0]    = OP;
        for (int k = 1; k < SW; k++) begin
            in_valid[k] = valid_q[k-1];
            in_data[k]  = data_q[k-1];
            in_s[k]     = s_q[k-1];
            in_op[k]    = op_q[k-1];
        end

        ready[SW] = O_READY;
        for (int k = SW - 1; k >= 0; k--) begin
            ready[k] = !valid_q[k] | ready[k+1];
        end

        for (int k = 0; k < SW; k++) begin
            shifted[k] = in_s[k][0] ? shift_pow2(in_data[k], in_op[k], k) : in_data[k];
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            valid_q <= '0;
            for (int k = 0; k < SW; k++) begin
                data_q[k] <= '0;
            end
            for (int k = 0; k < NCTL; k++) begin
                s_q[k]  <= '0;
                op_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < SW; k++) begin
                if (ready[k]) begin
                    valid_q[k] <= in_valid[k];
                    if (in_valid[k]) begin
                        data_q[k] <= shifted[k];
                    end
                end
            end
            // Remaining shift bits move down one position so each stage reads bit 0.
            for (int k = 0; k < SW - 1; k++) begin
                if (ready[k] && in_valid[k]) begin
                    s_q[k]  <= in_s[k] >> 1;
                    op_q[k] <= in_op[k];
                end
            end
        end
    end

    assign I_READY = ready[0];
    assign O       = data_q[SW-1];
    assign O_VALID = valid_q[SW-1];

endmodule
